ppu_vec: RTL and testbench

Parametrised, multi-lane post-processing unit. It takes LANES signed accumulator results per beat from the PE array or ofmap GLB and requantises each to signed OUT_W. Per lane: optional ReLU, unsigned scale multiply, round-half-up arithmetic shift, zero-point add, saturation. A passthrough mode forwards raw accumulators for the MLP3 step-0 path. The unit uses a 3-stage valid/ready pipeline with backpressure, frame-last propagation, and saturation/beat statistics.

---
 rtl/ppu_pkg.sv | 28 ++
 rtl/ppu_lane.sv | 93 +++++++++
 rtl/ppu_vec.sv | 107 ++++++++++
 tb/tb_ppu_vec.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared types, default widths and the output clamp helper for the post-processing unit.
package ppu_pkg;

    typedef enum logic {
        PPU_QUANT = 1'b0,
        PPU_PASS  = 1'b1
    } ppu_mode_e;

    localparam int PPU_LANES   = 8;
    localparam int PPU_ACC_W   = 32;
    localparam int PPU_SCALE_W = 12;
    localparam int PPU_SHIFT_W = 5;
    localparam int PPU_OUT_W   = 8;
    localparam int PPU_CNT_W   = 16;

    // Clamp a signed value to the range of a w-bit signed integer (w <= 64).
    function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                        input int unsigned       w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/ppu_lane.sv
// One lane of the requantiser: S1 ReLU/capture, S2 multiply, S3 round/shift/zp/clamp.
module ppu_lane
    import ppu_pkg::*;
#(
    parameter int ACC_W   = PPU_ACC_W,
    parameter int SCALE_W = PPU_SCALE_W,
    parameter int SHIFT_W = PPU_SHIFT_W,
    parameter int OUT_W   = PPU_OUT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               adv_i,
    input  logic [ACC_W-1:0]   acc_i,
    input  logic               mode_i,
    input  logic               relu_i,
    input  logic [SCALE_W-1:0] scale_i,
    input  logic [SHIFT_W-1:0] shift_i,
    input  logic [OUT_W-1:0]   zp_i,
    output logic [ACC_W-1:0]   data_o,
    output logic               sat_o
);
    localparam int PW = ACC_W + SCALE_W + 2;

    ppu_mode_e                s1_mode_q, s2_mode_q;
    logic signed [ACC_W-1:0]  s1_a_q, a_d;
    logic [SCALE_W-1:0]       s1_scale_q;
    logic [SHIFT_W-1:0]       s1_shift_q, s2_shift_q;
    logic [OUT_W-1:0]         s1_zp_q, s2_zp_q;
    logic signed [PW-1:0]     s2_p_q, p_d;
    logic [ACC_W-1:0]         s3_data_q, data_d;
    logic                     s3_sat_q, sat_d;

    logic signed [PW-1:0]     a_ext, sc_ext, zp_ext, rnd, r, q;
    logic signed [63:0]       q64, c;

    always_comb begin
        a_d = acc_i;
        if (ppu_mode_e'(mode_i) == PPU_QUANT && relu_i && acc_i[ACC_W-1])
            a_d = '0;

        // Passthrough rides the product register so S3 sees the raw accumulator.
        a_ext  = {{(PW-ACC_W){s1_a_q[ACC_W-1]}}, s1_a_q};
        sc_ext = {{(PW-SCALE_W){1'b0}}, s1_scale_q};
        p_d    = (s1_mode_q == PPU_PASS) ? a_ext : a_ext * sc_ext;

        // Half-LSB bias is 2^(shift-1), which collapses to 0 when shift is 0.
        rnd    = signed'(({{(PW-1){1'b0}}, 1'b1} << s2_shift_q) >> 1);
        r      = (s2_p_q + rnd) >>> s2_shift_q;
        zp_ext = {{(PW-OUT_W){s2_zp_q[OUT_W-1]}}, s2_zp_q};
        q      = r + zp_ext;
        q64    = {{(64-PW){q[PW-1]}}, q};
        c      = sat_to_width(q64, OUT_W);

        data_d = c[ACC_W-1:0];
        sat_d  = (c != q64);
        if (s2_mode_q == PPU_PASS) begin
            data_d = s2_p_q[ACC_W-1:0];
            sat_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_mode_q  <= PPU_QUANT;
            s1_a_q     <= '0;
            s1_scale_q <= '0;
            s1_shift_q <= '0;
            s1_zp_q    <= '0;
            s2_mode_q  <= PPU_QUANT;
            s2_p_q     <= '0;
            s2_shift_q <= '0;
            s2_zp_q    <= '0;
            s3_data_q  <= '0;
            s3_sat_q   <= 1'b0;
        end else if (adv_i) begin
            s1_mode_q  <= ppu_mode_e'(mode_i);
            s1_a_q     <= a_d;
            s1_scale_q <= scale_i;
            s1_shift_q <= shift_i;
            s1_zp_q    <= zp_i;
            s2_mode_q  <= s1_mode_q;
            s2_p_q     <= p_d;
            s2_shift_q <= s1_shift_q;
            s2_zp_q    <= s1_zp_q;
            s3_data_q  <= data_d;
            s3_sat_q   <= sat_d;
        end
    end

    assign data_o = s3_data_q;
    assign sat_o  = s3_sat_q;

endmodule

// File: rtl/ppu_vec.sv
// Multi-lane post-processing unit: lane array plus shared valid/last chain,
// valid/ready handshake and saturating beat/saturation statistics.
module ppu_vec
    import ppu_pkg::*;
#(
    parameter int LANES   = PPU_LANES,
    parameter int ACC_W   = PPU_ACC_W,
    parameter int SCALE_W = PPU_SCALE_W,
    parameter int SHIFT_W = PPU_SHIFT_W,
    parameter int OUT_W   = PPU_OUT_W,
    parameter int CNT_W   = PPU_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_mode,
    input  logic                   cfg_relu,
    input  logic [SCALE_W-1:0]     cfg_scale,
    input  logic [SHIFT_W-1:0]     cfg_shift,
    input  logic [OUT_W-1:0]       cfg_zp,
    input  logic                   i_valid,
    output logic                   i_ready,
    input  logic [LANES*ACC_W-1:0] i_data,
    input  logic                   i_last,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [LANES*ACC_W-1:0] o_data,
    output logic                   o_last,
    output logic                   busy,
    output logic [CNT_W-1:0]       sat_cnt,
    output logic [CNT_W-1:0]       beat_cnt,
    input  logic                   stat_clr
);
    localparam int SW = $clog2(LANES + 1);

    logic [3:1]       vld_q, last_q;
    logic             adv, fire;
    logic [LANES-1:0] sat;
    logic [SW-1:0]    nsat;
    logic [CNT_W:0]   sat_sum, beat_sum;
    logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d, beat_cnt_q, beat_cnt_d;

    // The whole pipe moves in lockstep; only a stalled S3 holds it.
    assign adv     = !(vld_q[3] && !o_ready);
    assign fire    = vld_q[3] && o_ready;
    assign i_ready = adv;
    assign o_valid = vld_q[3];
    assign o_last  = last_q[3];
    assign busy    = |vld_q;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        ppu_lane #(
            .ACC_W  (ACC_W),
            .SCALE_W(SCALE_W),
            .SHIFT_W(SHIFT_W),
            .OUT_W  (OUT_W)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .adv_i  (adv),
            .acc_i  (i_data[g*ACC_W +: ACC_W]),
            .mode_i (cfg_mode),
            .relu_i (cfg_relu),
            .scale_i(cfg_scale),
            .shift_i(cfg_shift),
            .zp_i   (cfg_zp),
            .data_o (o_data[g*ACC_W +: ACC_W]),
            .sat_o  (sat[g])
        );
    end

    always_comb begin
        nsat = '0;
        for (int i = 0; i < LANES; i++)
            nsat = nsat + SW'(sat[i]);
        sat_sum  = {1'b0, sat_cnt_q} + (CNT_W+1)'(nsat);
        beat_sum = {1'b0, beat_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
        sat_cnt_d  = sat_cnt_q;
        beat_cnt_d = beat_cnt_q;
        if (stat_clr) begin
            sat_cnt_d  = '0;
            beat_cnt_d = '0;
        end else if (fire) begin
            sat_cnt_d  = sat_sum[CNT_W]  ? '1 : sat_sum[CNT_W-1:0];
            beat_cnt_d = beat_sum[CNT_W] ? '1 : beat_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q      <= '0;
            last_q     <= '0;
            sat_cnt_q  <= '0;
            beat_cnt_q <= '0;
        end else begin
            if (adv) begin
                vld_q  <= {vld_q[2:1], i_valid};
                last_q <= {last_q[2:1], i_valid & i_last};
            end
            sat_cnt_q  <= sat_cnt_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign sat_cnt  = sat_cnt_q;
    assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_ppu_vec.sv
// Self-checking bench for ppu_vec: directed cases plus randomized traffic against
// an arithmetic reference model and an in-order expected-beat queue.
module tb_ppu_vec;
    localparam int LANES = 8, ACC_W = 32, SCALE_W = 12, SHIFT_W = 5, OUT_W = 8, CNT_W = 16;

    logic                   clk = 0, rst = 1;
    logic                   cfg_mode = 0, cfg_relu = 0;
    logic [SCALE_W-1:0]     cfg_scale = 0;
    logic [SHIFT_W-1:0]     cfg_shift = 0;
    logic [OUT_W-1:0]       cfg_zp = 0;
    logic                   i_valid = 0, i_ready, i_last = 0;
    logic [LANES*ACC_W-1:0] i_data = '0, o_data;
    logic                   o_valid, o_ready = 1, o_last, busy, stat_clr = 0;
    logic [CNT_W-1:0]       sat_cnt, beat_cnt;

    ppu_vec dut (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_relu(cfg_relu),
        .cfg_scale(cfg_scale), .cfg_shift(cfg_shift), .cfg_zp(cfg_zp),
        .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data), .i_last(i_last),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_last(o_last),
        .busy(busy), .sat_cnt(sat_cnt), .beat_cnt(beat_cnt), .stat_clr(stat_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LANES*ACC_W-1:0] data;
        bit                     last;
        int                     nsat;
        int                     cyc;
    } exp_t;

    exp_t                   expq[$];
    int                     n_tests = 0, n_fail = 0, cyc = 0, last_lat = 0;
    longint                 exp_sat = 0, exp_beat = 0;
    bit                     fired, accepted, was_stall = 0, hold_last;
    logic [LANES*ACC_W-1:0] hold_data, last_out;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the requantisation rules.
    function automatic logic [31:0] ref_lane(input logic signed [31:0] acc, input bit md,
                                             input bit rl, input int unsigned sc,
                                             input int unsigned sh, input logic signed [7:0] zp,
                                             output bit s);
        longint a, p, r, q;
        s = 0;
        if (md) return acc;
        a = longint'(acc);
        if (rl && a < 0) a = 0;
        p = a * longint'(sc);
        r = (sh == 0) ? p : ((p + (longint'(1) <<< (sh - 1))) >>> sh);
        q = r + longint'(zp);
        if (q > 127)  begin q = 127;  s = 1; end
        if (q < -128) begin q = -128; s = 1; end
        return q[31:0];
    endfunction

    // One cycle: inputs already driven after the falling edge; sample, model, advance.
    task automatic tick();
        exp_t e;
        #1;
        chk("sat_cnt", sat_cnt, exp_sat);
        chk("beat_cnt", beat_cnt, exp_beat);
        chk("busy", busy, expq.size() != 0);
        if (was_stall) begin
            chk("hold_data", o_data[63:0], hold_data[63:0]);
            chk("hold_last", o_last, hold_last);
        end
        was_stall = o_valid && !o_ready;
        if (was_stall) begin
            hold_data = o_data;
            hold_last = o_last;
            chk("irdy_stall", i_ready, 0);
        end
        fired = 0;
        accepted = 0;
        if (rst) begin
            expq.delete();
            exp_sat = 0;
            exp_beat = 0;
            was_stall = 0;
        end else begin
            if (o_valid && o_ready) begin
                fired = 1;
                if (expq.size() == 0) chk("spurious", o_valid, 0);
                else begin
                    e = expq.pop_front();
                    for (int l = 0; l < LANES; l++)
                        chk($sformatf("lane%0d", l), o_data[l*32 +: 32], e.data[l*32 +: 32]);
                    chk("last", o_last, e.last);
                    last_lat = cyc - e.cyc;
                    last_out = o_data;
                end
            end
            if (stat_clr) begin
                exp_sat = 0;
                exp_beat = 0;
            end else if (fired) begin
                exp_beat = (exp_beat + 1 > 65535) ? 65535 : exp_beat + 1;
                exp_sat  = (exp_sat + e.nsat > 65535) ? 65535 : exp_sat + e.nsat;
            end
            if (i_valid && i_ready) begin
                bit s;
                accepted = 1;
                e.nsat = 0;
                e.last = i_last;
                e.cyc  = cyc;
                for (int l = 0; l < LANES; l++) begin
                    e.data[l*32 +: 32] = ref_lane(i_data[l*32 +: 32], cfg_mode, cfg_relu,
                                                  cfg_scale, cfg_shift, cfg_zp, s);
                    e.nsat += s;
                end
                expq.push_back(e);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic single(input string tg, input logic [31:0] a0, input logic [31:0] a1,
                          input bit md, input bit rl, input int unsigned sc, input int unsigned sh,
                          input logic [7:0] zp, input logic [31:0] e0, input logic [31:0] e1);
        bit got = 0;
        cfg_mode = md; cfg_relu = rl; cfg_scale = SCALE_W'(sc); cfg_shift = SHIFT_W'(sh);
        cfg_zp = zp; i_data = '0; i_data[31:0] = a0; i_data[63:32] = a1;
        i_valid = 1; i_last = 1; o_ready = 1;
        tick();
        i_valid = 0;
        for (int n = 0; n < 10 && !got; n++) begin
            tick();
            if (fired) got = 1;
        end
        chk({tg, "_done"}, got, 1);
        chk({tg, "_lat"}, last_lat, 3);
        chk({tg, "_l0"}, last_out[31:0], e0);
        chk({tg, "_l1"}, last_out[63:32], e1);
    endtask

    task automatic rand_beat();
        cfg_mode  = ($urandom_range(0, 4) == 0);
        cfg_relu  = $urandom_range(0, 1);
        cfg_scale = SCALE_W'($urandom_range(0, 4095));
        cfg_shift = SHIFT_W'($urandom_range(0, 31));
        cfg_zp    = OUT_W'($urandom);
        for (int l = 0; l < LANES; l++) begin
            case ($urandom_range(0, 3))
                0: i_data[l*32 +: 32] = $urandom;
                1: i_data[l*32 +: 32] = 32'($signed($urandom_range(0, 400)) - 200);
                2: i_data[l*32 +: 32] = $urandom_range(0, 1) ? 32'h7FFFFFFF : 32'h80000000;
                default: i_data[l*32 +: 32] = 32'($urandom_range(0, 100000));
            endcase
        end
    endtask

    task automatic clear_stats();
        stat_clr = 1;
        tick();
        stat_clr = 0;
    endtask

    task automatic drain();
        i_valid = 0;
        o_ready = 1;
        for (int n = 0; n < 50 && expq.size() != 0; n++) tick();
        chk("drain", expq.size(), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 0;
        #1;
        chk("rst_ovalid", o_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_odata", o_data[63:0], 0);
        chk("rst_olast", o_last, 0);
        chk("rst_sat", sat_cnt, 0);
        chk("rst_beat", beat_cnt, 0);
        chk("rst_irdy", i_ready, 1);
        @(negedge clk);

        single("scale", 100, 100, 0, 0, 256, 8, 0, 100, 100);
        chk("scale_sat", sat_cnt, 0);
        single("rnd_p3", 3, 2, 0, 0, 1, 1, 0, 2, 1);
        single("rnd_m3", 32'hFFFFFFFD, 0, 0, 0, 1, 1, 0, 32'hFFFFFFFF, 0);
        clear_stats();
        single("sat_lo", 32'hFFFFFED4, 0, 0, 0, 128, 8, 0, 32'hFFFFFF80, 0);
        chk("sat_lo_cnt", sat_cnt, 1);
        single("sat_hi", 1000, 0, 0, 0, 205, 10, 0, 127, 0);
        chk("sat_hi_cnt", sat_cnt, 2);
        single("relu", 32'hFFFFFFCE, 0, 0, 1, 1, 0, 8'd10, 10, 10);
        single("pass", 32'h7FFFFFFF, 32'hFFFFFFFB, 1, 1, 5, 3, 8'd7, 32'h7FFFFFFF, 32'hFFFFFFFB);
        chk("pass_sat", sat_cnt, 2);

        // Six back-to-back beats; sink stalls for 5 cycles after the first delivery.
        clear_stats();
        begin
            int sent = 0, got = 0, stall_left = -1;
            for (int n = 0; n < 100 && got < 6; n++) begin
                if (!accepted || sent == 0) rand_beat();
                i_valid = (sent < 6);
                i_last  = (sent == 5);
                o_ready = !(stall_left > 0);
                tick();
                if (accepted) begin sent++; rand_beat(); end
                if (fired) begin
                    got++;
                    if (got == 1) stall_left = 5;
                end else if (stall_left > 0) stall_left--;
            end
            chk("bp_got", got, 6);
            chk("bp_beats", beat_cnt, 6);
        end
        drain();

        // Randomized traffic with random backpressure, config changes and clears.
        for (int n = 0; n < 400; n++) begin
            if (!i_valid || accepted) rand_beat();
            i_valid  = ($urandom_range(0, 3) != 0);
            i_last   = ($urandom_range(0, 4) == 0);
            o_ready  = ($urandom_range(0, 3) != 0);
            stat_clr = ($urandom_range(0, 40) == 0);
            tick();
        end
        stat_clr = 0;
        drain();

        // Reset with three beats in flight.
        o_ready = 1;
        for (int n = 0; n < 3; n++) begin
            rand_beat();
            i_valid = 1;
            tick();
        end
        i_valid = 0;
        rst = 1;
        tick();
        rst = 0;
        #1;
        chk("mrst_ovalid", o_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_sat", sat_cnt, 0);
        chk("mrst_beat", beat_cnt, 0);
        chk("mrst_irdy", i_ready, 1);
        for (int n = 0; n < 6; n++) tick();
        chk("mrst_nobeat", beat_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
